// File: rtl/pagerank_fixed_engine_if.sv
// Contribution stream into the pagerank engine: indexed beats with valid/ready and an end-of-iteration flag.
interface pagerank_fixed_engine_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
);
  logic             valid;
  logic             ready;
  logic [IDXW-1:0]  node;
  logic [WIDTH-1:0] value;
  logic             last;

  modport master (output valid, node, value, last, input ready);
  modport slave  (input valid, node, value, last, output ready);
endinterface

// File: rtl/pagerank_fixed_engine.sv
// Fixed-point pagerank iteration engine: accumulate, damp, measure delta, iterate to convergence or cap.
// Optional build macro PR_MAXNORM_EN switches the delta from L1 sum to L-infinity max.
module pagerank_fixed_engine #(
  parameter int NODES = 32,
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int IDXW  = $clog2(NODES)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      init_rank_i,
  input  logic [WIDTH-1:0]      damping_i,
  input  logic [WIDTH-1:0]      base_i,
  input  logic [WIDTH+IDXW-1:0] threshold_i,
  input  logic [31:0]           max_iter_i,
  pagerank_fixed_engine_if.slave in_s,
  input  logic [IDXW-1:0]       rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [31:0]           iteration_number_o,
  output logic                  next_iteration_o,
  output logic                  pagerank_complete_o,
  output logic                  idx_err_o
);
  localparam int AW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int DW = WIDTH + IDXW;
  localparam logic [IDXW:0] NODES_X = (IDXW+1)'(NODES);
  localparam logic [AW-1:0] LAST_N  = AW'(NODES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_UPDATE, S_CHECK, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}) >> FRAC;
    return (|p[2*WIDTH-1:WIDTH]) ? '1 : p[WIDTH-1:0];
  endfunction

  state_t                       state_q, state_d;
  logic [NODES-1:0][WIDTH-1:0]  rank_q, acc_q;
  logic [DW-1:0]                delta_q;
  logic [AW-1:0]                upd_q;
  logic [31:0]                  iter_q;
  logic                         idx_err_q;
  logic [WIDTH-1:0]             rd_data_q;

  logic             fire, in_range, rd_range, upd_last, fin;
  logic [31:0]      max_eff;
  logic [WIDTH-1:0] upd_new, upd_old, upd_diff;
  logic [DW-1:0]    diff_ext, delta_nxt;

  assign fire     = in_s.valid && in_s.ready;
  assign in_range = {1'b0, in_s.node} < NODES_X;
  assign rd_range = {1'b0, rd_addr_i} < NODES_X;
  assign upd_last = (upd_q == LAST_N);
  assign max_eff  = (max_iter_i == '0) ? 32'd1 : max_iter_i;
  // iter_q already holds the post-increment count while in CHECK
  assign fin      = (delta_q < threshold_i) || (iter_q >= max_eff);

  always_comb begin
    upd_old  = rank_q[upd_q];
    upd_new  = sat_add(base_i, sat_mul(damping_i, acc_q[upd_q]));
    upd_diff = (upd_new >= upd_old) ? (upd_new - upd_old) : (upd_old - upd_new);
    diff_ext = {{IDXW{1'b0}}, upd_diff};
`ifdef PR_MAXNORM_EN
    delta_nxt = (diff_ext > delta_q) ? diff_ext : delta_q;
`else
    delta_nxt = delta_q + diff_ext;
`endif
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_ACCUM;
      S_ACCUM:  if (fire && in_s.last) state_d = S_UPDATE;
      S_UPDATE: if (upd_last) state_d = S_CHECK;
      S_CHECK:  state_d = fin ? S_DONE : S_ACCUM;
      S_DONE:   if (start_i) state_d = S_ACCUM;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_s.ready          = 1'b0;
    next_iteration_o    = 1'b0;
    pagerank_complete_o = 1'b0;
    case (state_q)
      S_ACCUM: in_s.ready = 1'b1;
      S_CHECK: begin
        next_iteration_o    = !fin;
        pagerank_complete_o = fin;
      end
      S_DONE:  pagerank_complete_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rank_q    <= '0;
      acc_q     <= '0;
      delta_q   <= '0;
      upd_q     <= '0;
      iter_q    <= '0;
      idx_err_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_range ? rank_q[rd_addr_i[AW-1:0]] : '0;
      case (state_q)
        S_IDLE, S_DONE: if (start_i) begin
          for (int n = 0; n < NODES; n++) rank_q[n] <= init_rank_i;
          acc_q     <= '0;
          delta_q   <= '0;
          upd_q     <= '0;
          iter_q    <= '0;
          idx_err_q <= 1'b0;
        end
        S_ACCUM: if (fire) begin
          // out-of-range beats are dropped but still flagged
          if (in_range)
            acc_q[in_s.node[AW-1:0]] <= sat_add(acc_q[in_s.node[AW-1:0]], in_s.value);
          else
            idx_err_q <= 1'b1;
        end
        S_UPDATE: begin
          rank_q[upd_q] <= upd_new;
          acc_q[upd_q]  <= '0;
          delta_q       <= delta_nxt;
          upd_q         <= upd_last ? '0 : upd_q + 1'b1;
          if (upd_last) iter_q <= iter_q + 32'd1;
        end
        S_CHECK: if (!fin) delta_q <= '0;
        default: ;
      endcase
    end
  end

  assign rd_data_o          = rd_data_q;
  assign iteration_number_o = iter_q;
  assign idx_err_o          = idx_err_q;
endmodule

// File: tb/tb_pagerank_fixed_engine.sv
// Scoreboard bench for pagerank_fixed_engine: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_pagerank_fixed_engine;
  localparam int NODES = 4;
  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int IDXW  = 3;
  localparam int TW    = WIDTH + IDXW;
`ifdef PR_MAXNORM_EN
  localparam logic [TW-1:0] DELTA1 = 35'h0A332;
`else
  localparam logic [TW-1:0] DELTA1 = 35'h14667;
`endif

  typedef struct { bit done; int iter; int cyc; } ev_t;
  typedef struct { bit rdy; bit cmp; bit ierr; int iter; } st_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [WIDTH-1:0] init_rank, damping, base;
  logic [TW-1:0]    threshold;
  logic [31:0]      max_iter;
  logic [IDXW-1:0]  rd_addr = '0;
  logic [WIDTH-1:0] rd_data;
  logic [31:0]      iteration_number;
  logic next_iteration, pagerank_complete, idx_err;

  logic rd_req = 1'b0, rd_req_q = 1'b0, stat_req = 1'b0, cmp_prev = 1'b0;
  int cyc = 0, last_cyc = 0, checks = 0, errors = 0;
  ev_t ev_q[$];
  st_t st_q[$];
  logic [WIDTH-1:0] rd_q[$];

  pagerank_fixed_engine_if #(.WIDTH(WIDTH), .IDXW(IDXW)) sif ();

  pagerank_fixed_engine #(.NODES(NODES), .WIDTH(WIDTH), .FRAC(FRAC), .IDXW(IDXW)) dut (
    .clock_i(clk), .reset_i(reset), .start_i(start),
    .init_rank_i(init_rank), .damping_i(damping), .base_i(base),
    .threshold_i(threshold), .max_iter_i(max_iter), .in_s(sif),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .iteration_number_o(iteration_number),
    .next_iteration_o(next_iteration), .pagerank_complete_o(pagerank_complete), .idx_err_o(idx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_req_q <= rd_req;
  end

  always @(negedge clk) begin
    ev_t e; st_t s; logic [WIDTH-1:0] r;
    if (rd_req_q) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++; $display("FAIL rd_data: read with empty scoreboard");
      end else begin
        r = rd_q.pop_front();
        if (rd_data !== r) begin
          errors++; $display("FAIL rd_data got %h exp %h", rd_data, r);
        end
      end
    end
    if (stat_req) begin
      checks++;
      if (st_q.size() == 0) begin
        errors++; $display("FAIL status: probe with empty scoreboard");
      end else begin
        s = st_q.pop_front();
        if (sif.ready !== s.rdy || pagerank_complete !== s.cmp || idx_err !== s.ierr ||
            iteration_number !== s.iter || next_iteration !== 1'b0) begin
          errors++;
          $display("FAIL status got rdy=%b cmp=%b ierr=%b iter=%0d nxt=%b exp rdy=%b cmp=%b ierr=%b iter=%0d nxt=0",
                   sif.ready, pagerank_complete, idx_err, iteration_number, next_iteration,
                   s.rdy, s.cmp, s.ierr, s.iter);
        end
      end
    end
    if (next_iteration === 1'b1 || (pagerank_complete === 1'b1 && !cmp_prev)) begin
      checks++;
      if (ev_q.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected nxt=%b cmp=%b iter=%0d at cycle %0d",
                 next_iteration, pagerank_complete, iteration_number, cyc);
      end else begin
        e = ev_q.pop_front();
        if (pagerank_complete !== e.done || next_iteration !== !e.done ||
            iteration_number !== e.iter || cyc != e.cyc) begin
          errors++;
          $display("FAIL event got done=%b iter=%0d cyc=%0d exp done=%b iter=%0d cyc=%0d",
                   pagerank_complete, iteration_number, cyc, e.done, e.iter, e.cyc);
        end
      end
    end
    cmp_prev = (pagerank_complete === 1'b1);
  end

  task automatic step();
    @(posedge clk); #1;
    start = 1'b0; sif.valid = 1'b0; sif.last = 1'b0; rd_req = 1'b0; stat_req = 1'b0;
  endtask
  task automatic idle(input int n); repeat (n) step(); endtask
  task automatic do_start(); step(); start = 1'b1; endtask
  task automatic beat(input logic [IDXW-1:0] n, input logic [WIDTH-1:0] v, input bit l);
    step();
    sif.valid = 1'b1; sif.node = n; sif.value = v; sif.last = l;
    if (l) last_cyc = cyc;
  endtask
  task automatic expect_ev(input bit done, input int iter);
    ev_q.push_back('{done, iter, last_cyc + NODES + 1});
  endtask
  task automatic rd(input logic [IDXW-1:0] a, input logic [WIDTH-1:0] exp);
    step(); rd_addr = a; rd_req = 1'b1; rd_q.push_back(exp);
  endtask
  task automatic stat(input bit rdy, input bit cmp, input bit ierr, input int iter);
    step(); stat_req = 1'b1; st_q.push_back('{rdy, cmp, ierr, iter});
  endtask
  task automatic cfg_common();
    damping = 32'hD999; base = 32'h999; init_rank = 32'h4000; threshold = 35'h100; max_iter = 32'd10;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.valid = 1'b0; sif.last = 1'b0; sif.node = '0; sif.value = '0;
    cfg_common();
    idle(3);
    reset = 1'b0;
    stat(0, 0, 0, 0);
    rd(0, 32'h0);

    // single contribution, then a repeat stream with a stray start that must be ignored
    do_start();
    beat(0, 32'h10000, 1); expect_ev(0, 1);
    idle(7);
    rd(0, 32'hE332); rd(1, 32'h999); rd(3, 32'h999);
    stat(1, 0, 0, 1);
    do_start();
    beat(0, 32'h10000, 1); expect_ev(1, 2);
    idle(7);

    // delta exactly at threshold keeps iterating; one above converges
    threshold = DELTA1;
    do_start();
    beat(0, 32'h10000, 1); expect_ev(0, 1);
    idle(7);
    beat(0, 32'h10000, 1); expect_ev(1, 2);
    idle(7);
    threshold = DELTA1 + 35'd1;
    do_start();
    beat(0, 32'h10000, 1); expect_ev(1, 1);
    idle(7);

    // convergence
    threshold = 35'h10;
    do_start();
    for (int n = 0; n < NODES; n++) beat(n[IDXW-1:0], 32'h4000, n == NODES - 1);
    expect_ev(1, 1);
    idle(7);
    for (int n = 0; n < NODES; n++) rd(n[IDXW-1:0], 32'h3FFF);
    stat(0, 1, 0, 1);

    // iteration cap, then max_iter=0 treated as 1
    threshold = '0; max_iter = 32'd2;
    do_start();
    beat(0, 32'h10000, 1); expect_ev(0, 1);
    idle(7);
    beat(0, 32'h10000, 1); expect_ev(1, 2);
    idle(7);
    max_iter = 32'd0;
    do_start();
    beat(0, 32'h10000, 1); expect_ev(1, 1);
    idle(7);

    // same-node hazard and out-of-range index
    cfg_common();
    do_start();
    repeat (3) beat(1, 32'h8000, 0);
    beat(7, 32'h12345, 1); expect_ev(0, 1);
    idle(7);
    rd(1, 32'h14FFE); rd(0, 32'h999); rd(3, 32'h999);
    stat(1, 0, 1, 1);
    repeat (3) beat(1, 32'h8000, 0);
    beat(7, 32'h12345, 1); expect_ev(1, 2);
    idle(7);
    stat(0, 1, 1, 2);

    // saturation; start clears idx_err
    damping = 32'h10000; base = 32'h10; max_iter = 32'd1;
    do_start();
    stat(1, 0, 0, 0);
    beat(2, 32'hFFFF0000, 0);
    beat(2, 32'hFFFF0000, 1); expect_ev(1, 1);
    idle(7);
    rd(2, 32'hFFFFFFFF); rd(0, 32'h10);

    // reset in the second UPDATE cycle
    cfg_common();
    do_start();
    beat(0, 32'h10000, 1);
    step();
    step(); reset = 1'b1; rd_addr = 0; rd_req = 1'b1; rd_q.push_back(32'h0);
    step(); reset = 1'b0; stat_req = 1'b1; st_q.push_back('{1'b0, 1'b0, 1'b0, 0});
    idle(3);
    do_start();
    beat(0, 32'h10000, 1); expect_ev(0, 1);
    idle(7);
    rd(0, 32'hE332); rd(2, 32'h999);
    idle(2);

    checks++;
    if (ev_q.size() != 0) begin errors++; $display("FAIL events: %0d expected events never seen", ev_q.size()); end
    checks++;
    if (rd_q.size() + st_q.size() != 0) begin
      errors++; $display("FAIL probes: %0d reads %0d status checks left", rd_q.size(), st_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
